omsp_sm_id_alloc: RTL and testbench

- Parametrised successor of the SM control block. Owns SM slot selection, ID allocation and execution-context tracking for an array of NB_SMS protected-module slots.
- Adds three things the legacy block lacks:
  - a two-phase grant/commit handshake for SM creation;
  - an ID recycling FIFO, so destroyed IDs are reused before fresh IDs are minted;
  - parametrised ID and IRQ-range widths.
- Sits between the execution unit's SM instruction decode and the omsp_spm slot array.

---
 rtl/omsp_sm_pkg.sv | 11 +
 rtl/omsp_sm_id_fifo.sv | 42 ++++
 rtl/omsp_sm_id_alloc.sv | 129 ++++++++++++
 tb/tb_omsp_sm_id_alloc.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/omsp_sm_pkg.sv
// omsp_sm_pkg: shared types and helpers for the SM ID allocator
package omsp_sm_pkg;
  typedef enum logic {IDLE, GRANT} state_e;
  // First ID of the reserved IRQ range, 2^id_w - 2^irq_w, reduced modulo 2^32
  function automatic logic [31:0] irq_base(input int id_w, input int irq_w);
    return (32'd1 << id_w) - (32'd1 << irq_w);
  endfunction
  function automatic logic [15:0] first_one(input logic [15:0] v);
    return v & (~v + 16'd1);
  endfunction
endpackage

// File: rtl/omsp_sm_id_fifo.sv
// omsp_sm_id_fifo: synchronous FIFO holding freed SM IDs, with head peek
module omsp_sm_id_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] peek_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign empty_o = cnt_q == '0;
  assign full_o = cnt_q == CW'(DEPTH);
  assign peek_o = mem_q[rd_q];
  assign do_pop = pop_i & ~empty_o;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  assign do_push = push_i & (~full_o | do_pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= din_i;
      wr_q <= do_push ? nxt(wr_q) : wr_q;
      rd_q <= do_pop ? nxt(rd_q) : rd_q;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/omsp_sm_id_alloc.sv
// omsp_sm_id_alloc: SM slot selection, ID allocation with recycling, and execution-context tracking
module omsp_sm_id_alloc
  import omsp_sm_pkg::*;
#(
  parameter int NB_SMS = 4,
  parameter int ID_W = 16,
  parameter int IRQ_W = 4,
  parameter int RECYCLE_DEPTH = 4
) (
  input  logic                   mclk,
  input  logic                   puc_rst,
  input  logic                   alloc_req,
  input  logic                   alloc_commit,
  input  logic                   alloc_cancel,
  input  logic                   free_req,
  input  logic [ID_W-1:0]        free_id,
  input  logic [NB_SMS-1:0]      slot_enabled,
  input  logic [NB_SMS-1:0]      slot_executing,
  input  logic [NB_SMS*ID_W-1:0] slot_id,
  input  logic                   handling_irq,
  input  logic [IRQ_W-1:0]       irq_num,
  output logic                   alloc_busy,
  output logic [NB_SMS-1:0]      alloc_slot,
  output logic [ID_W-1:0]        alloc_id,
  output logic [NB_SMS-1:0]      check_mask,
  output logic                   alloc_fail,
  output logic [ID_W-1:0]        current_id,
  output logic [ID_W-1:0]        prev_id,
  output logic                   enter_sm,
  output logic                   exit_sm,
  output logic                   exec_sm,
  output logic                   multi_exec,
  output logic                   id_exhausted,
  output logic                   free_overflow
);
  localparam logic [ID_W-1:0] IRQ_BASE = ID_W'(irq_base(ID_W, IRQ_W));
  state_e state_q, state_d;
  logic [NB_SMS-1:0] slot_q, slot_d, free_slot;
  logic [ID_W-1:0] id_q, id_d, next_fresh_q, next_fresh_d, fifo_head;
  logic [ID_W-1:0] prev_cycle_id_q, prev_id_q;
  logic src_fifo_q, src_fifo_d, fail_q, fail_d, overflow_q, overflow_d;
  logic fifo_empty, fifo_full, fifo_pop, push_req;
  logic no_slot, fresh_out, can_grant, commit, changed;
  assign free_slot = NB_SMS'(first_one(16'(~slot_enabled)));
  assign no_slot = &slot_enabled;
  assign fresh_out = next_fresh_q == IRQ_BASE;
  assign id_exhausted = fresh_out & fifo_empty;
  assign can_grant = ~no_slot & ~id_exhausted;
  // Cancel beats commit, so a simultaneous pair never consumes the offered ID
  assign commit = (state_q == GRANT) & alloc_commit & ~alloc_cancel;
  assign fifo_pop = commit & src_fifo_q;
  assign push_req = (RECYCLE_DEPTH > 0) & free_req & (free_id != '0) & (free_id < IRQ_BASE);
  generate
    if (RECYCLE_DEPTH > 0) begin : g_fifo
      omsp_sm_id_fifo #(.W(ID_W), .DEPTH(RECYCLE_DEPTH)) u_fifo (
        .clk(mclk),
        .rst(puc_rst),
        .push_i(push_req),
        .din_i(free_id),
        .pop_i(fifo_pop),
        .peek_o(fifo_head),
        .full_o(fifo_full),
        .empty_o(fifo_empty)
      );
    end else begin : g_nofifo
      assign fifo_head = '0;
      assign fifo_full = 1'b1;
      assign fifo_empty = 1'b1;
    end
  endgenerate
  always_ff @(posedge mclk) begin
    if (puc_rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) state_d = (alloc_req & can_grant) ? GRANT : IDLE;
    else state_d = (alloc_commit | alloc_cancel) ? IDLE : GRANT;
  end
  always_comb begin
    alloc_busy = state_q == GRANT;
    alloc_slot = slot_q;
    alloc_id = id_q;
    check_mask = alloc_busy ? slot_enabled & ~slot_q : '0;
    alloc_fail = fail_q;
    free_overflow = overflow_q;
    prev_id = prev_id_q;
  end
  always_comb begin
    slot_d = (state_q == IDLE && alloc_req && can_grant) ? free_slot : (state_d == IDLE ? '0 : slot_q);
    id_d = (state_q == IDLE && alloc_req && can_grant) ? (fifo_empty ? next_fresh_q : fifo_head) : id_q;
    src_fifo_d = (state_q == IDLE && alloc_req && can_grant) ? ~fifo_empty : src_fifo_q;
    fail_d = (state_q == IDLE) & alloc_req & ~can_grant;
    next_fresh_d = (commit & ~src_fifo_q & ~fresh_out) ? next_fresh_q + 1'b1 : next_fresh_q;
    overflow_d = overflow_q | (push_req & fifo_full & ~fifo_pop);
  end
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      slot_q <= '0;
      id_q <= '0;
      src_fifo_q <= 1'b0;
      fail_q <= 1'b0;
      next_fresh_q <= ID_W'(1);
      overflow_q <= 1'b0;
      prev_cycle_id_q <= '0;
      prev_id_q <= '0;
    end else begin
      slot_q <= slot_d;
      id_q <= id_d;
      src_fifo_q <= src_fifo_d;
      fail_q <= fail_d;
      next_fresh_q <= next_fresh_d;
      overflow_q <= overflow_d;
      prev_cycle_id_q <= current_id;
      prev_id_q <= changed ? prev_cycle_id_q : prev_id_q;
    end
  end
  // Lowest-index executing slot wins; IRQ entry overrides with the reserved range
  always_comb begin
    current_id = '0;
    for (int k = NB_SMS - 1; k >= 0; k--) current_id = slot_executing[k] ? slot_id[k*ID_W +: ID_W] : current_id;
    current_id = handling_irq ? IRQ_BASE + ID_W'(irq_num) : current_id;
  end
  assign changed = current_id != prev_cycle_id_q;
  assign enter_sm = changed & (current_id != '0) & ~(&current_id) & ~handling_irq;
  assign exit_sm = changed & (current_id == '0) & ~handling_irq;
  assign exec_sm = |slot_executing;
  assign multi_exec = $countones(slot_executing) > 1;
endmodule

// File: tb/tb_omsp_sm_id_alloc.sv
// tb_omsp_sm_id_alloc: directed self-checking bench, 4 slots, 8-bit IDs, IRQ base 240
module tb_omsp_sm_id_alloc;
  logic mclk, puc_rst, alloc_req, alloc_commit, alloc_cancel, free_req, handling_irq;
  logic [7:0] free_id, alloc_id, current_id, prev_id;
  logic [3:0] slot_enabled, slot_executing, irq_num, alloc_slot, check_mask;
  logic [31:0] slot_id;
  logic alloc_busy, alloc_fail, enter_sm, exit_sm, exec_sm, multi_exec, id_exhausted, free_overflow;
  int errors = 0;
  int checks = 0;
  omsp_sm_id_alloc #(.NB_SMS(4), .ID_W(8), .IRQ_W(4), .RECYCLE_DEPTH(4)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .alloc_req(alloc_req), .alloc_commit(alloc_commit),
    .alloc_cancel(alloc_cancel), .free_req(free_req), .free_id(free_id),
    .slot_enabled(slot_enabled), .slot_executing(slot_executing), .slot_id(slot_id),
    .handling_irq(handling_irq), .irq_num(irq_num), .alloc_busy(alloc_busy),
    .alloc_slot(alloc_slot), .alloc_id(alloc_id), .check_mask(check_mask),
    .alloc_fail(alloc_fail), .current_id(current_id), .prev_id(prev_id),
    .enter_sm(enter_sm), .exit_sm(exit_sm), .exec_sm(exec_sm), .multi_exec(multi_exec),
    .id_exhausted(id_exhausted), .free_overflow(free_overflow)
  );
  initial mclk = 1'b0;
  always #5 mclk = ~mclk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge mclk);
    #1;
  endtask
  task automatic grant(input logic [3:0] en, input logic [7:0] exp_id, input logic [3:0] exp_slot, input string tag);
    alloc_req = 1'b1;
    slot_enabled = en;
    tick();
    alloc_req = 1'b0;
    chk({tag, "_busy"}, alloc_busy, 1);
    chk({tag, "_id"}, alloc_id, exp_id);
    chk({tag, "_slot"}, alloc_slot, exp_slot);
  endtask
  task automatic finish_grant(input logic c, input logic x, input string tag);
    alloc_commit = c;
    alloc_cancel = x;
    tick();
    alloc_commit = 1'b0;
    alloc_cancel = 1'b0;
    chk({tag, "_idle"}, alloc_busy, 0);
  endtask
  task automatic free(input logic [7:0] id);
    free_req = 1'b1;
    free_id = id;
    tick();
    free_req = 1'b0;
  endtask
  initial begin
    puc_rst = 1'b1; alloc_req = 0; alloc_commit = 0; alloc_cancel = 0; free_req = 0; free_id = 0;
    slot_enabled = 0; slot_executing = 0; slot_id = 0; handling_irq = 0; irq_num = 0;
    tick(); tick();
    puc_rst = 1'b0;
    chk("rst_busy", alloc_busy, 0);
    chk("rst_slot", alloc_slot, 0);
    chk("rst_id", alloc_id, 0);
    chk("rst_fail", alloc_fail, 0);
    chk("rst_prev", prev_id, 0);
    chk("rst_ovf", free_overflow, 0);
    chk("rst_cur", current_id, 0);
    chk("rst_exh", id_exhausted, 0);
    // first grant from the fresh counter
    grant(4'b0000, 1, 4'b0001, "g1");
    slot_enabled = 4'b0101;
    #1 chk("g1_mask", check_mask, 4'b0100);
    finish_grant(1, 0, "g1c");
    chk("g1c_slot", alloc_slot, 0);
    chk("idle_mask", check_mask, 0);
    // requests during GRANT are ignored; cancel beats commit
    grant(4'b0001, 2, 4'b0010, "g2");
    alloc_req = 1'b1;
    tick();
    alloc_req = 1'b0;
    chk("g2_hold_busy", alloc_busy, 1);
    chk("g2_hold_id", alloc_id, 2);
    finish_grant(1, 1, "g2cc");
    grant(4'b0001, 2, 4'b0010, "g2b");
    finish_grant(0, 1, "g2bx");
    grant(4'b0001, 2, 4'b0010, "g2c");
    finish_grant(0, 1, "g2cx");
    // no free slot
    alloc_req = 1'b1;
    slot_enabled = 4'b1111;
    tick();
    alloc_req = 1'b0;
    chk("full_fail", alloc_fail, 1);
    chk("full_busy", alloc_busy, 0);
    tick();
    chk("full_fail_pulse", alloc_fail, 0);
    // recycled ID is preferred over fresh
    free(1);
    grant(4'b0001, 1, 4'b0010, "r1");
    finish_grant(1, 0, "r1c");
    grant(4'b0001, 2, 4'b0010, "r1f");
    finish_grant(0, 1, "r1fx");
    // single entry: push and pop together leave the new entry
    free(7);
    grant(4'b0000, 7, 4'b0001, "r7");
    alloc_commit = 1'b1;
    free_req = 1'b1;
    free_id = 9;
    tick();
    alloc_commit = 1'b0;
    free_req = 1'b0;
    grant(4'b0000, 9, 4'b0001, "r9");
    finish_grant(1, 0, "r9c");
    grant(4'b0000, 2, 4'b0001, "r9f");
    finish_grant(0, 1, "r9fx");
    // out-of-range frees ignored, then fill and overflow
    free(0);
    free(240);
    free(255);
    chk("ovf_ign", free_overflow, 0);
    for (int i = 10; i < 14; i++) free(8'(i));
    chk("ovf_full", free_overflow, 0);
    free(14);
    chk("ovf_set", free_overflow, 1);
    for (int i = 10; i < 14; i++) begin
      grant(4'b0000, 8'(i), 4'b0001, "fifo");
      finish_grant(1, 0, "fifoc");
    end
    grant(4'b0000, 2, 4'b0001, "fifo_fresh");
    finish_grant(0, 1, "fifo_freshx");
    chk("ovf_sticky", free_overflow, 1);
    // consume every fresh ID up to IRQ_BASE
    for (int i = 2; i < 240; i++) begin
      grant(4'b0000, 8'(i), 4'b0001, "fresh");
      finish_grant(1, 0, "freshc");
    end
    chk("exh_set", id_exhausted, 1);
    alloc_req = 1'b1;
    tick();
    alloc_req = 1'b0;
    chk("exh_fail", alloc_fail, 1);
    chk("exh_busy", alloc_busy, 0);
    tick();
    chk("exh_fail_pulse", alloc_fail, 0);
    free(50);
    chk("exh_clr", id_exhausted, 0);
    grant(4'b0000, 50, 4'b0001, "exh_rec");
    finish_grant(1, 0, "exh_recc");
    chk("exh_again", id_exhausted, 1);
    // reset during GRANT discards it
    free(60);
    grant(4'b0000, 60, 4'b0001, "mid");
    puc_rst = 1'b1;
    tick();
    puc_rst = 1'b0;
    chk("mid_busy", alloc_busy, 0);
    chk("mid_ovf", free_overflow, 0);
    chk("mid_exh", id_exhausted, 0);
    grant(4'b0000, 1, 4'b0001, "post");
    finish_grant(0, 1, "postx");
    // execution-context tracking
    slot_id = 32'h0009_0500;
    slot_executing = 4'b0010;
    #1;
    chk("ctx_cur5", current_id, 5);
    chk("ctx_enter", enter_sm, 1);
    chk("ctx_exit0", exit_sm, 0);
    chk("ctx_exec", exec_sm, 1);
    chk("ctx_multi0", multi_exec, 0);
    tick();
    chk("ctx_enter_pulse", enter_sm, 0);
    chk("ctx_prev0", prev_id, 0);
    handling_irq = 1'b1;
    irq_num = 3;
    #1;
    chk("irq_cur", current_id, 243);
    chk("irq_enter", enter_sm, 0);
    tick();
    chk("irq_prev", prev_id, 5);
    handling_irq = 1'b0;
    #1;
    chk("irq_ret_enter", enter_sm, 1);
    tick();
    chk("irq_ret_prev", prev_id, 243);
    slot_executing = 4'b0110;
    #1;
    chk("multi_cur", current_id, 5);
    chk("multi", multi_exec, 1);
    chk("multi_enter", enter_sm, 0);
    slot_executing = 4'b0000;
    #1;
    chk("exit_cur", current_id, 0);
    chk("exit", exit_sm, 1);
    chk("exit_enter", enter_sm, 0);
    tick();
    chk("exit_pulse", exit_sm, 0);
    chk("exit_prev", prev_id, 5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
